// File: rtl/ms_wb_pkg.sv
// Shared definitions for the Wishbone classic burst master: FSM encoding,
// address step and timeout counter width.
package ms_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    BUS,
    RESP,
    FIN
  } state_t;

  localparam int          TMO_W    = 16;
  localparam logic [31:0] ADR_STEP = 32'd4;

  // Word-aligned increment; wraps naturally at 32 bits (0xFFFFFFFC -> 0).
  function automatic logic [31:0] next_adr(input logic [31:0] adr);
    return adr + ADR_STEP;
  endfunction

endpackage

// File: rtl/ms_wb_tmo_cnt.sv
// Per-beat Wishbone timeout counter: held at zero while cleared, counts
// enabled cycles, flags the cycle whose increment would reach LIMIT.
module ms_wb_tmo_cnt
  import ms_wb_pkg::*;
#(
  parameter logic [TMO_W-1:0] LIMIT = TMO_W'(255)
)
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [TMO_W-1:0] r_count;
  logic [TMO_W-1:0] w_count_inc;

  assign w_count_inc = r_count + TMO_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_count_inc;
    end
  end

  // Expiry is only meaningful on a waiting cycle, so an ack in the same cycle wins.
  assign o_expire = i_enable && (w_count_inc == LIMIT);

endmodule

// File: rtl/ms_wb_master.sv
// Wishbone classic initiator: turns a command (address, length, byte select)
// into a burst of single beats fed by write/read data streams, with per-beat timeout.
module ms_wb_master
  import ms_wb_pkg::*;
#(
  parameter int TIMEOUT = 255
)
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [3:0]  cmd_len,
  input  logic [3:0]  cmd_sel,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        err,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  state_t      r_state;
  logic        r_we;
  logic [3:0]  r_len;
  logic [3:0]  r_beat;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [31:0] r_rd_data;
  logic        r_cmd_ready;
  logic        r_wr_ready;
  logic        r_rd_valid;
  logic        r_done;
  logic        r_err;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we_o;

  logic        w_expire;
  logic        w_tmo_clear;
  logic        w_tmo_enable;
  logic        w_advance;
  logic        w_last;

  assign w_tmo_clear  = (r_state != BUS);
  assign w_tmo_enable = (r_state == BUS) && !ack_i;
  // A beat is finished when a write is acked or a read word is taken downstream.
  assign w_advance    = ((r_state == BUS) && ack_i && r_we) ||
                        ((r_state == RESP) && rd_ready);
  assign w_last       = (r_beat == r_len);

  ms_wb_tmo_cnt #(
    .LIMIT (TMO_LIMIT)
  ) u_tmo_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clear  (w_tmo_clear),
    .i_enable (w_tmo_enable),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_len       <= '0;
      r_beat      <= '0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rd_data   <= '0;
      r_cmd_ready <= 1'b1;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we_o      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_we        <= cmd_we;
            r_adr       <= cmd_adr;
            r_len       <= cmd_len;
            r_sel       <= cmd_sel;
            r_beat      <= '0;
            r_cmd_ready <= 1'b0;
            r_cyc       <= 1'b1;
            r_we_o      <= cmd_we;
            if (cmd_we) begin
              r_wr_ready <= 1'b1;
              r_state    <= WDATA;
            end else begin
              r_stb   <= 1'b1;
              r_state <= BUS;
            end
          end
        end
        WDATA: begin
          if (wr_valid) begin
            r_dat      <= wr_data;
            r_wr_ready <= 1'b0;
            r_stb      <= 1'b1;
            r_state    <= BUS;
          end
        end
        BUS: begin
          if (ack_i) begin
            r_stb <= 1'b0;
            if (!r_we) begin
              r_rd_data  <= dat_i;
              r_rd_valid <= 1'b1;
              r_state    <= RESP;
            end
          end else if (w_expire) begin
            r_stb   <= 1'b0;
            r_cyc   <= 1'b0;
            r_we_o  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= FIN;
          end
        end
        RESP: begin
          if (rd_ready) begin
            r_rd_valid <= 1'b0;
          end
        end
        FIN: begin
          r_done      <= 1'b0;
          r_err       <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // Next-beat decision overrides the per-state next state above.
      if (w_advance) begin
        if (w_last) begin
          r_cyc   <= 1'b0;
          r_we_o  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= FIN;
        end else begin
          r_beat <= r_beat + 4'd1;
          r_adr  <= next_adr(r_adr);
          if (r_we) begin
            r_wr_ready <= 1'b1;
            r_state    <= WDATA;
          end else begin
            r_stb   <= 1'b1;
            r_state <= BUS;
          end
        end
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign wr_ready  = r_wr_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign done      = r_done;
  assign err       = r_err;
  assign adr_o     = r_adr;
  assign dat_o     = r_dat;
  assign sel_o     = r_sel;
  assign cyc_o     = r_cyc;
  assign stb_o     = r_stb;
  assign we_o      = r_we_o;

endmodule
